// File: rtl/sm_seg_scanner_if.sv
// Bus between the GPIO matrix and the seven-segment scanner: digit data in,
// registered display pins and their packed GPIO word out.
interface sm_seg_scanner_if;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  dpIn;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frameStrobe;
    logic [15:0] gpioOutput;

    modport master (
        output enable, data, dpIn,
        input  anode, seg, dp, frameStrobe, gpioOutput
    );

    modport slave (
        input  enable, data, dpIn,
        output anode, seg, dp, frameStrobe, gpioOutput
    );
endinterface

// File: rtl/sm_seg_scanner.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with prescaled
// scan, per-slot dead time and a frame-synchronous shadow latch.
module sm_seg_scanner #(
    parameter int unsigned DIV_WIDTH       = 10,
    parameter int unsigned BLANK_CYCLES    = 16,
    parameter int unsigned LEAD_ZERO_BLANK = 0
) (
    input  logic             clk,
    input  logic             rst,
    sm_seg_scanner_if.slave  bus
);
    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DATA_W = DIGITS * NIB_W;
    localparam int unsigned IDX_W  = 2;

    logic [DIV_WIDTH-1:0] presc_q,   presc_n;
    logic [IDX_W-1:0]     idx_q,     idx_n;
    logic [DATA_W-1:0]    sh_data_q, sh_data_n;
    logic [DIGITS-1:0]    sh_dp_q,   sh_dp_n;
    logic [DIGITS-1:0]    anode_q,   anode_n;
    logic [SEG_W-1:0]     seg_q,     seg_n;
    logic                 dp_q,      dp_n;
    logic                 strobe_q,  strobe_n;

    logic                 tick_c;
    logic                 frame_end_c;
    logic                 blank_c;
    logic [NIB_W-1:0]     nibble_c;
    logic [DIGITS-1:0]    zero_c;
    logic [DIGITS-1:0]    dark_c;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign tick_c      = bus.enable && (presc_q == '1);
    assign frame_end_c = tick_c && (idx_q == IDX_W'(DIGITS - 1));
    assign blank_c     = presc_q < DIV_WIDTH'(BLANK_CYCLES);
    assign nibble_c    = sh_data_q[{idx_q, 2'b00} +: NIB_W];

    // A digit goes dark only while it and every digit above it are blank zeros.
    always_comb begin
        zero_c = '0;
        dark_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            zero_c[i] = (sh_data_q[i*NIB_W +: NIB_W] == '0) && !sh_dp_q[i];
        end
        if (LEAD_ZERO_BLANK != 0) begin
            dark_c[3] = zero_c[3];
            dark_c[2] = dark_c[3] & zero_c[2];
            dark_c[1] = dark_c[2] & zero_c[1];
            dark_c[0] = 1'b0;
        end
    end

    always_comb begin
        presc_n   = presc_q;
        idx_n     = idx_q;
        sh_data_n = sh_data_q;
        sh_dp_n   = sh_dp_q;
        anode_n   = '0;
        seg_n     = seg_q;
        dp_n      = dp_q;
        strobe_n  = 1'b0;

        if (bus.enable) begin
            presc_n = presc_q + DIV_WIDTH'(1);
            if (tick_c) begin
                idx_n = idx_q + IDX_W'(1);
            end
            // Shadow loads at the frame boundary so a digit never shows mixed data.
            if (frame_end_c) begin
                sh_data_n = bus.data;
                sh_dp_n   = bus.dpIn;
                strobe_n  = 1'b1;
            end

            if (dark_c[idx_q]) begin
                anode_n = '0;
                seg_n   = '0;
                dp_n    = 1'b0;
            end else begin
                anode_n = blank_c ? '0 : (DIGITS'(1) << idx_q);
                seg_n   = hex_to_seg(nibble_c);
                dp_n    = sh_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            anode_q   <= '0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            presc_q   <= presc_n;
            idx_q     <= idx_n;
            sh_data_q <= sh_data_n;
            sh_dp_q   <= sh_dp_n;
            anode_q   <= anode_n;
            seg_q     <= seg_n;
            dp_q      <= dp_n;
            strobe_q  <= strobe_n;
        end
    end

    assign bus.anode       = anode_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frameStrobe = strobe_q;
    assign bus.gpioOutput  = {4'b0000, anode_q, seg_q, dp_q};
endmodule
